// File: rtl/split_check_sequencer.sv
// split_check_sequencer: walks one candidate through NUM_SPLITS shared split checkers.
// Define SPLIT_SEQ_EARLY_EXIT_EN to end evaluation at the first failing split.
module split_check_sequencer #(
    parameter int NUM_SPLITS = 8,
    parameter int IDX_W      = 3,
    parameter int DATA_W     = 21,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cand_valid,
    output logic              cand_ready,
    input  logic [DATA_W-1:0] cand_data,
    output logic [IDX_W-1:0]  split_sel,
    output logic [DATA_W-1:0] split_data,
    input  logic              split_x,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_pass,
    output logic [IDX_W-1:0]  res_fail_idx,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_SEL = IDX_W'(NUM_SPLITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t             state_q;
    state_t             state_d;
    logic               fail_q;
    logic [IDX_W-1:0]   fail_idx_q;
    logic               accept;
    logic               in_eval;
    logic               hit_fail;
    logic               any_fail;
    logic               eval_done;
    logic [IDX_W-1:0]   first_idx;

    assign accept    = cand_valid && cand_ready;
    assign in_eval   = (state_q == EVAL);
    assign hit_fail  = in_eval && !split_x;
    assign any_fail  = fail_q || hit_fail;
    // An earlier recorded failure always outranks the split seen this cycle.
    assign first_idx = fail_q ? fail_idx_q : split_sel;

`ifdef SPLIT_SEQ_EARLY_EXIT_EN
    assign eval_done = in_eval && ((split_sel == LAST_SEL) || hit_fail);
`else
    assign eval_done = in_eval && (split_sel == LAST_SEL);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            (state_q == IDLE): begin
                if (cand_valid) state_d = EVAL;
            end
            (state_q == EVAL): begin
                if (eval_done) state_d = RESP;
            end
            (state_q == RESP): begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cand_ready = (state_q == IDLE);
        res_valid  = (state_q == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            split_sel  <= '0;
            split_data <= '0;
            fail_q     <= 1'b0;
            fail_idx_q <= '0;
        end else if (accept) begin
            split_sel  <= '0;
            split_data <= cand_data;
            fail_q     <= 1'b0;
            fail_idx_q <= '0;
        end else if (in_eval) begin
            if (hit_fail && !fail_q) begin
                fail_q     <= 1'b1;
                fail_idx_q <= split_sel;
            end
            if (!eval_done) begin
                split_sel <= split_sel + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_pass     <= 1'b0;
            res_fail_idx <= '0;
        end else if (eval_done) begin
            res_pass     <= !any_fail;
            res_fail_idx <= any_fail ? first_idx : '0;
        end
    end

    // A clear coinciding with a verdict wins over that verdict's increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (clr_stats) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (eval_done) begin
            if (!any_fail && pass_cnt != CNT_MAX) begin
                pass_cnt <= pass_cnt + CNT_W'(1);
            end
            if (any_fail && fail_cnt != CNT_MAX) begin
                fail_cnt <= fail_cnt + CNT_W'(1);
            end
        end
    end

endmodule
